// File: rtl/konami_cs_decoder_seq_if.sv
// CPU-side bus bundle for the programmable chip-select decoder: strobe,
// address, mode/config write ports, and the decoded selects and handshake.
interface konami_cs_decoder_seq_if #(
  parameter int ADDR_W = 16,
  parameter int NCS    = 8,
  parameter int MODE_W = 4,
  parameter int WAIT_W = 3
);
  localparam int IDX_W = (NCS > 1) ? $clog2(NCS) : 1;

  logic              as_n;
  logic [ADDR_W-1:0] addr;
  logic              mode_we;
  logic [MODE_W-1:0] mode_d;
  logic              cfg_we;
  logic [IDX_W-1:0]  cfg_idx;
  logic [1:0]        cfg_field;
  logic [ADDR_W-1:0] cfg_data;
  logic [NCS-1:0]    cs_n;
  logic              any_cs_n;
  logic              ready;
  logic              miss;
  logic [MODE_W-1:0] mode_q;

  modport master (
    output as_n, addr, mode_we, mode_d, cfg_we, cfg_idx, cfg_field, cfg_data,
    input  cs_n, any_cs_n, ready, miss, mode_q
  );

  modport slave (
    input  as_n, addr, mode_we, mode_d, cfg_we, cfg_idx, cfg_field, cfg_data,
    output cs_n, any_cs_n, ready, miss, mode_q
  );
endinterface

// File: rtl/konami_cs_decoder_seq.sv
// Registered, runtime-programmable chip-select decoder with per-region
// mode qualifiers and a wait-state counter that paces bus ready.
module konami_cs_decoder_seq #(
  parameter int ADDR_W = 16,
  parameter int NCS    = 8,
  parameter int MODE_W = 4,
  parameter int WAIT_W = 3
) (
  input logic                    clk,
  input logic                    reset,
  konami_cs_decoder_seq_if.slave bus
);
  localparam int IDX_W = (NCS > 1) ? $clog2(NCS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_READY,
    ST_MISSED
  } state_e;

  logic [ADDR_W-1:0] base_q [NCS];
  logic [ADDR_W-1:0] mask_q [NCS];
  logic [MODE_W-1:0] care_q [NCS];
  logic [MODE_W-1:0] val_q  [NCS];
  logic              en_q   [NCS];
  logic [WAIT_W-1:0] wait_q [NCS];

  logic [MODE_W-1:0] mode_q;
  logic              as_n_q;
  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic [NCS-1:0]    cs_n_q, cs_n_d;
  logic              ready_q, ready_d;
  logic              miss_q, miss_d;

  logic              capture;
  logic              hit_found;
  logic [IDX_W-1:0]  hit_idx;

  // Mode and region tables; a capture in the same cycle still sees old values.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q <= '0;
      for (int i = 0; i < NCS; i++) begin
        base_q[i] <= '0;
        mask_q[i] <= '0;
        care_q[i] <= '0;
        val_q[i]  <= '0;
        en_q[i]   <= 1'b0;
        wait_q[i] <= '0;
      end
    end else begin
      if (bus.mode_we) begin
        mode_q <= bus.mode_d;
      end
      if (bus.cfg_we && (int'(bus.cfg_idx) < NCS)) begin
        case (bus.cfg_field)
          2'd0: base_q[bus.cfg_idx] <= bus.cfg_data;
          2'd1: mask_q[bus.cfg_idx] <= bus.cfg_data;
          2'd2: begin
            care_q[bus.cfg_idx] <= bus.cfg_data[2*MODE_W-1:MODE_W];
            val_q[bus.cfg_idx]  <= bus.cfg_data[MODE_W-1:0];
          end
          default: begin
            en_q[bus.cfg_idx]   <= bus.cfg_data[WAIT_W];
            wait_q[bus.cfg_idx] <= bus.cfg_data[WAIT_W-1:0];
          end
        endcase
      end
    end
  end

  // Lowest-numbered matching region wins, so overlays sit at lower indices.
  always_comb begin
    hit_found = 1'b0;
    hit_idx   = '0;
    for (int i = 0; i < NCS; i++) begin
      if (!hit_found && en_q[i] &&
          ((bus.addr & mask_q[i]) == (base_q[i] & mask_q[i])) &&
          ((mode_q & care_q[i]) == (val_q[i] & care_q[i]))) begin
        hit_found = 1'b1;
        hit_idx   = IDX_W'(i);
      end
    end
  end

  assign capture = as_n_q & ~bus.as_n;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    miss_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (capture) begin
          if (hit_found) begin
            idx_d   = hit_idx;
            cnt_d   = wait_q[hit_idx];
            state_d = (wait_q[hit_idx] == '0) ? ST_READY : ST_WAIT;
          end else begin
            state_d = ST_MISSED;
            miss_d  = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (bus.as_n) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - WAIT_W'(1);
          if (cnt_q == WAIT_W'(1)) begin
            state_d = ST_READY;
          end
        end
      end
      default: begin
        if (bus.as_n) begin
          state_d = ST_IDLE;
        end
      end
    endcase

    // Outputs are registered from the next state so selects appear one clock after capture.
    cs_n_d = '1;
    if ((state_d == ST_WAIT) || (state_d == ST_READY)) begin
      cs_n_d[idx_d] = 1'b0;
    end
    ready_d = (state_d == ST_READY) || (state_d == ST_MISSED);
  end

  // as_n_q resets low so a strobe already asserted at reset release is not captured.
  always_ff @(posedge clk) begin
    if (reset) begin
      as_n_q  <= 1'b0;
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      cs_n_q  <= '1;
      ready_q <= 1'b0;
      miss_q  <= 1'b0;
    end else begin
      as_n_q  <= bus.as_n;
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      cs_n_q  <= cs_n_d;
      ready_q <= ready_d;
      miss_q  <= miss_d;
    end
  end

  assign bus.cs_n     = cs_n_q;
  assign bus.any_cs_n = &cs_n_q;
  assign bus.ready    = ready_q;
  assign bus.miss     = miss_q;
  assign bus.mode_q   = mode_q;
endmodule

// File: tb/tb_konami_cs_decoder_seq.sv
// Bench for konami_cs_decoder_seq: directed bus-map scenarios followed by
// randomized traffic, all compared against a cycle-age reference model.
module tb_konami_cs_decoder_seq;
  localparam int ADDR_W = 16;
  localparam int NCS    = 8;
  localparam int MODE_W = 4;
  localparam int WAIT_W = 3;
  localparam int IDX_W  = $clog2(NCS);

  logic clk;
  logic reset;

  konami_cs_decoder_seq_if #(
    .ADDR_W(ADDR_W), .NCS(NCS), .MODE_W(MODE_W), .WAIT_W(WAIT_W)
  ) bus ();

  konami_cs_decoder_seq #(
    .ADDR_W(ADDR_W), .NCS(NCS), .MODE_W(MODE_W), .WAIT_W(WAIT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic              rstIn;
  logic              asIn;
  logic [ADDR_W-1:0] addrIn;
  logic              modeWeIn;
  logic [MODE_W-1:0] modeDIn;
  logic              cfgWeIn;
  logic [IDX_W-1:0]  cfgIdxIn;
  logic [1:0]        cfgFieldIn;
  logic [ADDR_W-1:0] cfgDataIn;

  int mBase [NCS];
  int mMask [NCS];
  int mCare [NCS];
  int mVal  [NCS];
  int mWait [NCS];
  bit mEn   [NCS];
  int mMode;
  bit mPrevAs;
  bit mActive;
  int mAge;
  int mIdx;
  int mCapWait;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
    end
  endtask

  function automatic int findRegion(input int a, input int m);
    for (int i = 0; i < NCS; i++) begin
      if (mEn[i] && (((a ^ mBase[i]) & mMask[i]) == 0) && (((m ^ mVal[i]) & mCare[i]) == 0))
        return i;
    end
    return -1;
  endfunction

  // Reference: a bus cycle is "active" from capture until as_n is seen high; outputs follow its age.
  task automatic modelStep();
    if (rstIn) begin
      for (int i = 0; i < NCS; i++) begin
        mBase[i] = 0; mMask[i] = 0; mCare[i] = 0; mVal[i] = 0; mWait[i] = 0; mEn[i] = 0;
      end
      mMode = 0; mPrevAs = 0; mActive = 0; mAge = 0; mIdx = -1; mCapWait = 0;
    end else begin
      if (mActive) begin
        if (asIn) mActive = 0;
        else mAge++;
      end
      if (mPrevAs && !asIn) begin
        mActive  = 1;
        mAge     = 0;
        mIdx     = findRegion(int'(addrIn), mMode);
        mCapWait = (mIdx >= 0) ? mWait[mIdx] : 0;
      end
      if (modeWeIn) mMode = int'(modeDIn);
      if (cfgWeIn && int'(cfgIdxIn) < NCS) begin
        case (cfgFieldIn)
          2'd0: mBase[cfgIdxIn] = int'(cfgDataIn);
          2'd1: mMask[cfgIdxIn] = int'(cfgDataIn);
          2'd2: begin
            mCare[cfgIdxIn] = (int'(cfgDataIn) >> MODE_W) & ((1 << MODE_W) - 1);
            mVal[cfgIdxIn]  = int'(cfgDataIn) & ((1 << MODE_W) - 1);
          end
          default: begin
            mEn[cfgIdxIn]   = cfgDataIn[WAIT_W];
            mWait[cfgIdxIn] = int'(cfgDataIn) & ((1 << WAIT_W) - 1);
          end
        endcase
      end
      mPrevAs = asIn;
    end
  endtask

  // Drive one cycle of inputs, advance the model, then compare after the edge.
  task automatic applyStimulus();
    logic [NCS-1:0] expCs;
    logic           expReady;
    logic           expMiss;
    reset         = rstIn;
    bus.as_n      = asIn;
    bus.addr      = addrIn;
    bus.mode_we   = modeWeIn;
    bus.mode_d    = modeDIn;
    bus.cfg_we    = cfgWeIn;
    bus.cfg_idx   = cfgIdxIn;
    bus.cfg_field = cfgFieldIn;
    bus.cfg_data  = cfgDataIn;
    modelStep();
    expCs = '1; expReady = 1'b0; expMiss = 1'b0;
    if (mActive) begin
      if (mIdx >= 0) begin
        expCs[mIdx] = 1'b0;
        expReady    = (mAge >= mCapWait);
      end else begin
        expReady = 1'b1;
        expMiss  = (mAge == 0);
      end
    end
    @(posedge clk);
    @(negedge clk);
    checkOutput("cs_n", 32'(bus.cs_n), 32'(expCs));
    checkOutput("any_cs_n", 32'(bus.any_cs_n), 32'(&expCs));
    checkOutput("ready", 32'(bus.ready), 32'(expReady));
    checkOutput("miss", 32'(bus.miss), 32'(expMiss));
    checkOutput("mode_q", 32'(bus.mode_q), 32'(mMode));
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  task automatic cfgWrite(input int idx, input int field, input int data);
    cfgWeIn = 1'b1; cfgIdxIn = IDX_W'(idx); cfgFieldIn = 2'(field); cfgDataIn = ADDR_W'(data);
    applyStimulus();
    cfgWeIn = 1'b0;
  endtask

  task automatic modeWrite(input int m);
    modeWeIn = 1'b1; modeDIn = MODE_W'(m);
    applyStimulus();
    modeWeIn = 1'b0;
  endtask

  task automatic strobeOnce(input int a);
    asIn = 1'b0; addrIn = ADDR_W'(a);
    applyStimulus();
  endtask

  initial begin
    rstIn = 1'b1; asIn = 1'b1; addrIn = '0; modeWeIn = 1'b0; modeDIn = '0;
    cfgWeIn = 1'b0; cfgIdxIn = '0; cfgFieldIn = '0; cfgDataIn = '0;
    cycles(2);
    checkOutput("rst_cs_n", 32'(bus.cs_n), 32'hFF);
    checkOutput("rst_ready", 32'(bus.ready), 32'h0);
    rstIn = 1'b0;
    cycles(1);

    // Nothing enabled: the strobe misses but still gets ready.
    strobeOnce(16'h1234);
    checkOutput("plan_miss", 32'(bus.miss), 32'h1);
    checkOutput("plan_miss_ready", 32'(bus.ready), 32'h1);
    checkOutput("plan_miss_cs", 32'(bus.cs_n), 32'hFF);
    strobeOnce(16'h1234);
    checkOutput("plan_miss_pulse", 32'(bus.miss), 32'h0);
    asIn = 1'b1; cycles(1);

    cfgWrite(1, 0, 16'h2000);
    cfgWrite(1, 1, 16'hE000);
    cfgWrite(1, 2, 16'h0010);
    cfgWrite(1, 3, 16'h0008);
    modeWrite(0);
    strobeOnce(16'h2ABC);
    checkOutput("plan_r1_cs", 32'(bus.cs_n), 32'hFD);
    checkOutput("plan_r1_ready", 32'(bus.ready), 32'h1);
    asIn = 1'b1; cycles(1);
    checkOutput("plan_r1_release", 32'(bus.cs_n), 32'hFF);
    modeWrite(1);
    strobeOnce(16'h2ABC);
    checkOutput("plan_r1_mode_miss", 32'(bus.miss), 32'h1);
    asIn = 1'b1; cycles(1);

    // Overlay at index 0 wins only while its mode qualifier matches.
    cfgWrite(0, 0, 16'h0000);
    cfgWrite(0, 1, 16'hFC00);
    cfgWrite(0, 2, 16'h0022);
    cfgWrite(0, 3, 16'h0008);
    cfgWrite(2, 0, 16'h0000);
    cfgWrite(2, 1, 16'hE000);
    cfgWrite(2, 3, 16'h0008);
    modeWrite(2);
    strobeOnce(16'h0100);
    checkOutput("plan_overlay_on", 32'(bus.cs_n), 32'hFE);
    asIn = 1'b1; cycles(1);
    modeWrite(0);
    strobeOnce(16'h0100);
    checkOutput("plan_overlay_off", 32'(bus.cs_n), 32'hFB);
    asIn = 1'b1; cycles(1);

    cfgWrite(3, 0, 16'h4000);
    cfgWrite(3, 1, 16'hE000);
    cfgWrite(3, 3, 16'h000B);
    strobeOnce(16'h4000);
    checkOutput("plan_w3_cs", 32'(bus.cs_n), 32'hF7);
    checkOutput("plan_w3_r0", 32'(bus.ready), 32'h0);
    cycles(2);
    checkOutput("plan_w3_r2", 32'(bus.ready), 32'h0);
    cycles(1);
    checkOutput("plan_w3_r3", 32'(bus.ready), 32'h1);
    asIn = 1'b1; cycles(1);
    strobeOnce(16'h4000);
    cycles(2);
    asIn = 1'b1; cycles(1);
    checkOutput("plan_short_cs", 32'(bus.cs_n), 32'hFF);
    checkOutput("plan_short_ready", 32'(bus.ready), 32'h0);

    // Config write coinciding with capture must not affect that capture.
    cfgWeIn = 1'b1; cfgIdxIn = IDX_W'(1); cfgFieldIn = 2'd0; cfgDataIn = 16'h6000;
    strobeOnce(16'h2ABC);
    cfgWeIn = 1'b0;
    checkOutput("plan_cfg_old", 32'(bus.cs_n), 32'hFD);
    asIn = 1'b1; cycles(1);
    strobeOnce(16'h2ABC);
    checkOutput("plan_cfg_new_miss", 32'(bus.miss), 32'h1);
    asIn = 1'b1; cycles(1);
    strobeOnce(16'h6123);
    checkOutput("plan_cfg_new_hit", 32'(bus.cs_n), 32'hFD);

    rstIn = 1'b1; cycles(1);
    checkOutput("plan_rst_mid", 32'(bus.cs_n), 32'hFF);
    rstIn = 1'b0; cycles(3);
    checkOutput("plan_rst_nocap", 32'(bus.cs_n), 32'hFF);
    checkOutput("plan_rst_nomiss", 32'(bus.miss), 32'h0);
    asIn = 1'b1; cycles(1);
    strobeOnce(16'h6123);
    checkOutput("plan_rst_recap", 32'(bus.miss), 32'h1);
    asIn = 1'b1; cycles(1);

    for (int n = 0; n < 3000; n++) begin
      rstIn    = ($urandom_range(0, 399) == 0);
      modeWeIn = ($urandom_range(0, 9) == 0);
      modeDIn  = MODE_W'($urandom);
      cfgWeIn  = ($urandom_range(0, 4) == 0);
      cfgIdxIn = IDX_W'($urandom_range(0, NCS - 1));
      cfgFieldIn = 2'($urandom);
      case ($urandom_range(0, 3))
        0: cfgDataIn = 16'hE000;
        1: cfgDataIn = 16'hF000;
        2: cfgDataIn = ADDR_W'($urandom_range(0, 255));
        default: cfgDataIn = ADDR_W'($urandom);
      endcase
      if ($urandom_range(0, 2) == 0) asIn = ~asIn;
      if ($urandom_range(0, 1) == 0) begin
        int r;
        r = $urandom_range(0, NCS - 1);
        addrIn = ADDR_W'((mBase[r] & mMask[r]) | (int'($urandom) & ~mMask[r]));
      end else begin
        addrIn = ADDR_W'($urandom);
      end
      applyStimulus();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/konami_cs_decoder_seq.md
Name: konami_cs_decoder_seq

Overview:
- Runtime-programmable, registered chip-select decoder for Konami-style 6809/68000 bus maps.
- Generalises the fixed PAL decode used on the board:
  - NCS configurable regions, each defined by address base/mask plus mode-bit qualifiers (BK4/WOCO-like bank and overlay bits).
  - Per-region wait-state counter generating bus ready.
- Sits between the CPU bus strobe/address and the RAM/ROM/IO selects.
- Replaces one or more combinational PALs with a single clocked block.

Parameters:
- ADDR_W, 16, address width.
- NCS, 8, number of regions/chip selects (2..16).
- MODE_W, 4, number of mode qualifier bits.
- WAIT_W, 3, wait-state counter width.
- Constraint: ADDR_W >= 2*MODE_W and ADDR_W >= WAIT_W+1.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, synchronous active-high reset.
- as_n, in, 1, CPU address strobe, active low, synchronous to clk.
- addr, in, ADDR_W, CPU address.
- mode_we, in, 1, write strobe for the mode register.
- mode_d, in, MODE_W, mode register data (bit0=BK4-like, bit1=WOCO-like, etc.).
- cfg_we, in, 1, region config write strobe.
- cfg_idx, in, clog2(NCS), region index.
- cfg_field, in, 2, field select: 0 base, 1 mask, 2 {care,val}, 3 {en,wait}.
- cfg_data, in, ADDR_W, config data.
- cs_n, out, NCS, registered chip selects, active low, one-hot-low.
- any_cs_n, out, 1, low when any cs_n is low.
- ready, out, 1, bus cycle may complete.
- miss, out, 1, one-cycle pulse when a strobe hits no region.
- mode_q, out, MODE_W, current mode register.

Behaviour:
- Reset:
  - cs_n all 1, any_cs_n 1, ready 0, miss 0, mode_q 0.
  - All region fields 0, so all regions disabled.
  - FSM to IDLE; internal as_n_q reset to 0.
- Clock and reset: one clock domain. Reset is synchronous and active-high.
- Region hit i = en_i & ((addr & mask_i) == (base_i & mask_i)) & ((mode_q & care_i) == (val_i & care_i)).
- Priority: lowest index wins on overlap. Overlays such as WOCO=1 over RAM are expressed by a lower index.
- Capture:
  - A strobe start is as_n_q==1 and as_n==0.
  - On that edge: latch the winning index, load the counter with wait_i.
  - Decode uses addr and mode_q as sampled that cycle.
- cs_n:
  - cs_n[idx] goes low on the clock following capture (1-cycle latency).
  - Held low while as_n stays low. addr changes mid-cycle are ignored.
  - Returns high on the clock after as_n is sampled high.
- FSM:
  - IDLE: on capture with hit → WAIT if wait_i>0, else READY; on capture with miss → MISSED.
  - WAIT: counter decrements each clock; at 1→0 go to READY. as_n high → IDLE.
  - READY: ready=1 while as_n low. as_n high → IDLE, ready=0 the next cycle.
  - MISSED: miss=1 for the first cycle only; ready=1 so the bus never hangs; no cs_n asserted; as_n high → IDLE.
- Ready timing: wait=0 gives ready together with cs_n low; wait=N gives ready N cycles after cs_n low.
- Back-to-back strobes: as_n high for a single sample is sufficient; the next falling edge is captured normally.
- A strobe shorter than the wait count ends the cycle: IDLE, cs_n high, ready never asserted.
- mode_we: mode_q updates next clock. A simultaneous capture uses the old mode_q.
- cfg_we: field updates next clock. A simultaneous capture uses old values. The active cycle is unaffected (index and counter already latched).
- Field packing in cfg_data:
  - Field 2: care=cfg_data[2*MODE_W-1:MODE_W], val=cfg_data[MODE_W-1:0].
  - Field 3: en=cfg_data[WAIT_W], wait=cfg_data[WAIT_W-1:0].
- Reset asserted mid-cycle: outputs take their reset values next clock. Because as_n_q resets to 0, a strobe already low at reset release is not captured until as_n returns high and falls again.
- Out-of-range cfg_idx (>= NCS): write is ignored.

Test Plan:
- Reset, then as_n low with addr=0x1234 and no region enabled → miss=1 for one cycle, ready=1, cs_n=0xFF.
- Region1 base=0x2000, mask=0xE000, care=0x1, val=0x0, en=1, wait=0; mode_d=0; strobe addr=0x2ABC → cs_n=0xFD one clock after the edge, ready the same cycle. With mode_d=0x1, the same strobe → miss.
- Overlap: region0 base=0x0000 mask=0xFC00 care=0x2 val=0x2; region2 base=0x0000 mask=0xE000. mode=0x2, addr=0x0100 → cs_n[0] low. mode=0x0 → cs_n[2] low.
- Region3 wait=3: ready rises exactly 3 clocks after cs_n[3] falls. Raise as_n after 2 clocks → cs_n returns high, ready stays 0.
- cfg_we changing region1 base, issued on the same clock as a capture → the current cycle decodes with the old base; the next strobe uses the new one.
- Reset asserted while cs_n[1] low and as_n held low → cs_n=0xFF next clock; no new capture until as_n goes high then low.
